// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// The state enum doubles as the state_o encoding.
package hazard_pkg;

   localparam int DEF_MEM_TIMEOUT = 255;
   localparam int DEF_CNT_W       = 16;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             async_reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a five-stage pipeline: load-use bubbles,
// taken-branch flushes, data-memory wait stalls with a sticky timeout.
//
// state      | meaning
// RUN        | normal flow, load-use hazards are checked
// LOAD_STALL | one bubble already inserted, load-use ignored this cycle
// MEM_WAIT   | data memory not ready, whole pipe frozen, wait_cnt running
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             async_reset,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rd_E,
   input  logic             mem_read_E,
   input  logic             reg_write_E,
   input  logic             branch_taken_E,
   input  logic             mem_req_M,
   input  logic             mem_ready_M,
   output logic             enable_F,
   output logic             enable_D,
   output logic             enable_E,
   output logic             enable_M,
   output logic             enable_W,
   output logic             sync_reset_D,
   output logic             sync_reset_E,
   output logic [1:0]       state_o,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   hz_state_e         state;
   hz_state_e         state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_nxt;
   logic              timeout_q;
   logic              load_use;
   logic              mem_stall;
   logic              flush_evt;

   assign load_use  = mem_read_E & reg_write_E & (rd_E != 5'd0) &
                      ((rd_E == rs1_D) | (rd_E == rs2_D));
   assign mem_stall = mem_req_M & ~mem_ready_M;

   always_ff @(posedge clock or negedge async_reset) begin
      if (!async_reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if ((state_nxt == MEM_WAIT) && (wait_nxt == WAIT_MAX)) begin
            timeout_q <= 1'b1;
         end
      end
   end

   // Priority: memory stall freezes everything, then branch flush, then load-use.
   always_comb begin
      state_nxt    = RUN;
      enable_F     = 1'b1;
      enable_D     = 1'b1;
      enable_E     = 1'b1;
      enable_M     = 1'b1;
      enable_W     = 1'b1;
      sync_reset_D = 1'b1;
      sync_reset_E = 1'b1;
      flush_evt    = 1'b0;

      if (mem_stall) begin
         enable_F  = 1'b0;
         enable_D  = 1'b0;
         enable_E  = 1'b0;
         enable_M  = 1'b0;
         enable_W  = 1'b0;
         state_nxt = MEM_WAIT;
      end else if (branch_taken_E) begin
         sync_reset_D = 1'b0;
         sync_reset_E = 1'b0;
         flush_evt    = 1'b1;
      end else if (load_use && (state != LOAD_STALL)) begin
         enable_F     = 1'b0;
         enable_D     = 1'b0;
         sync_reset_E = 1'b0;
         state_nxt    = LOAD_STALL;
      end

      // Outputs are combinational, so reset must force them directly.
      if (!async_reset) begin
         enable_F     = 1'b0;
         enable_D     = 1'b0;
         enable_E     = 1'b0;
         enable_M     = 1'b0;
         enable_W     = 1'b0;
         sync_reset_D = 1'b0;
         sync_reset_E = 1'b0;
         flush_evt    = 1'b0;
         state_nxt    = RUN;
      end
   end

   always_comb begin
      wait_nxt = '0;
      if (state_nxt == MEM_WAIT) begin
         if (state != MEM_WAIT) begin
            wait_nxt = WAIT_W'(1);
         end else if (wait_cnt == WAIT_MAX) begin
            wait_nxt = wait_cnt;
         end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
         end
      end
   end

   assign state_o     = state;
   assign timeout_err = timeout_q;

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clock       (clock),
      .async_reset (async_reset),
      .inc         (~enable_F),
      .count       (stall_cycles)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clock       (clock),
      .async_reset (async_reset),
      .inc         (flush_evt),
      .count       (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios then random traffic,
// all checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

   localparam int TO   = 8;
   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic          clock          = 1'b0;
   logic          async_reset    = 1'b1;
   logic [4:0]    rs1_D          = '0;
   logic [4:0]    rs2_D          = '0;
   logic [4:0]    rd_E           = '0;
   logic          mem_read_E     = 1'b0;
   logic          reg_write_E    = 1'b0;
   logic          branch_taken_E = 1'b0;
   logic          mem_req_M      = 1'b0;
   logic          mem_ready_M    = 1'b0;
   logic          enable_F, enable_D, enable_E, enable_M, enable_W;
   logic          sync_reset_D, sync_reset_E;
   logic [1:0]    state_o;
   logic          timeout_err;
   logic [CW-1:0] stall_cycles, flush_count;

   int vectors     = 0;
   int miscompares = 0;

   // model: consecutive stalled cycles, bubble flag, sticky timeout, counters
   int m_wait    = 0;
   int m_stall   = 0;
   int m_flush   = 0;
   bit m_bubble  = 1'b0;
   bit m_timeout = 1'b0;
   int burst     = 0;

   pipeline_hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clock          (clock),
      .async_reset    (async_reset),
      .rs1_D          (rs1_D),
      .rs2_D          (rs2_D),
      .rd_E           (rd_E),
      .mem_read_E     (mem_read_E),
      .reg_write_E    (reg_write_E),
      .branch_taken_E (branch_taken_E),
      .mem_req_M      (mem_req_M),
      .mem_ready_M    (mem_ready_M),
      .enable_F       (enable_F),
      .enable_D       (enable_D),
      .enable_E       (enable_E),
      .enable_M       (enable_M),
      .enable_W       (enable_W),
      .sync_reset_D   (sync_reset_D),
      .sync_reset_E   (sync_reset_E),
      .state_o        (state_o),
      .timeout_err    (timeout_err),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      rs1_D = '0; rs2_D = '0; rd_E = '0;
      mem_read_E = 1'b0; reg_write_E = 1'b0; branch_taken_E = 1'b0;
      mem_req_M = 1'b0; mem_ready_M = 1'b0;
   endtask

   task automatic do_reset();
      async_reset = 1'b0;
      #1;
      check("rst_enables", {enable_F, enable_D, enable_E, enable_M, enable_W}, 0);
      check("rst_sync_d", sync_reset_D, 0);
      check("rst_sync_e", sync_reset_E, 0);
      check("rst_state", state_o, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_stall_cnt", stall_cycles, 0);
      check("rst_flush_cnt", flush_count, 0);
      m_wait = 0; m_stall = 0; m_flush = 0; m_bubble = 1'b0; m_timeout = 1'b0;
      repeat (2) @(posedge clock);
      #1 async_reset = 1'b1;
   endtask

   // One clock cycle with the inputs currently applied.
   task automatic step();
      bit ms, lu, br, bub;
      logic [4:0] en;
      logic srd, sre;
      int st;
      ms  = mem_req_M && !mem_ready_M;
      br  = branch_taken_E;
      lu  = mem_read_E && reg_write_E && (rd_E != 0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
      st  = (m_wait > 0) ? 2 : (m_bubble ? 1 : 0);
      en  = 5'b11111; srd = 1'b1; sre = 1'b1; bub = 1'b0;
      if (ms) en = 5'b00000;
      else if (br) begin srd = 1'b0; sre = 1'b0; end
      else if (lu && !m_bubble) begin en = 5'b00111; sre = 1'b0; bub = 1'b1; end
      @(negedge clock);
      check("enables", {enable_F, enable_D, enable_E, enable_M, enable_W}, en);
      check("sync_reset_D", sync_reset_D, srd);
      check("sync_reset_E", sync_reset_E, sre);
      check("state_o", state_o, st);
      check("timeout_err", timeout_err, m_timeout);
      check("stall_cycles", stall_cycles, m_stall);
      check("flush_count", flush_count, m_flush);
      @(posedge clock);
      if (!en[4] && m_stall < CMAX) m_stall++;
      if (!ms && br && m_flush < CMAX) m_flush++;
      if (ms) begin
         if (m_wait < TO) m_wait++;
         if (m_wait == TO) m_timeout = 1'b1;
      end else begin
         m_wait = 0;
      end
      m_bubble = bub;
      #1;
   endtask

   initial begin
      #2;
      do_reset();

      // load-use on rs1: one bubble, then LOAD_STALL ignores the same hazard
      clear_inputs();
      rd_E = 5'd5; mem_read_E = 1'b1; reg_write_E = 1'b1; rs1_D = 5'd5;
      step();
      step();
      check("lu_stall_cnt", stall_cycles, 1);
      check("lu_back_to_run", state_o, 0);

      // x0 never hazards
      rd_E = 5'd0; rs1_D = 5'd0;
      step();
      check("x0_stall_cnt", stall_cycles, 1);

      // four memory-wait cycles then ready
      do_reset();
      clear_inputs();
      mem_req_M = 1'b1;
      repeat (4) step();
      check("mw_state", state_o, 2);
      mem_ready_M = 1'b1;
      step();
      check("mw_stall_cnt", stall_cycles, 4);
      check("mw_exit_state", state_o, 0);

      // branch wins over load-use
      do_reset();
      clear_inputs();
      rd_E = 5'd5; mem_read_E = 1'b1; reg_write_E = 1'b1; rs2_D = 5'd5; branch_taken_E = 1'b1;
      step();
      check("br_flush_cnt", flush_count, 1);
      check("br_stall_cnt", stall_cycles, 0);

      // timeout after 8 wait cycles, sticky past ready, cleared by reset
      do_reset();
      clear_inputs();
      mem_req_M = 1'b1;
      repeat (7) step();
      check("to_not_yet", timeout_err, 0);
      step();
      check("to_set", timeout_err, 1);
      repeat (2) step();
      mem_ready_M = 1'b1;
      repeat (2) step();
      check("to_sticky", timeout_err, 1);
      check("to_sat_stall", stall_cycles, 10);

      // reset aborts MEM_WAIT
      do_reset();
      clear_inputs();
      mem_req_M = 1'b1;
      repeat (3) step();
      check("abort_state", state_o, 2);
      do_reset();
      check("abort_release_state", state_o, 0);
      clear_inputs();
      step();

      // randomized traffic with occasional long memory waits and resets
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 499) do_reset();
         if (burst > 0) begin
            burst--;
            mem_req_M = 1'b1; mem_ready_M = 1'b0;
         end else begin
            if ($urandom_range(0, 40) == 0) burst = $urandom_range(6, 12);
            mem_req_M   = ($urandom_range(0, 3) == 0);
            mem_ready_M = ($urandom_range(0, 2) != 0);
         end
         rd_E           = 5'($urandom_range(0, 3));
         rs1_D          = 5'($urandom_range(0, 3));
         rs2_D          = 5'($urandom_range(0, 3));
         mem_read_E     = ($urandom_range(0, 1) == 1);
         reg_write_E    = ($urandom_range(0, 3) != 0);
         branch_taken_E = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, the memory-wait cycle count at which timeout_err sets.
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of the performance counters.
REQ-003 Port clock SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port async_reset SHALL be input, 1 bit: reset, asynchronous, active-low.
REQ-005 Ports rs1_D and rs2_D SHALL be inputs, 5 bits each: source registers of the instruction in Decode.
REQ-006 Port rd_E SHALL be input, 5 bits: destination register of the instruction in Execute.
REQ-007 Ports mem_read_E, reg_write_E and branch_taken_E SHALL be inputs, 1 bit each: Execute-stage load flag, writeback flag and resolved-taken branch/jump.
REQ-008 Ports mem_req_M and mem_ready_M SHALL be inputs, 1 bit each: Memory-stage access request and data-memory ready.
REQ-009 Ports enable_F, enable_D, enable_E, enable_M and enable_W SHALL be outputs, 1 bit each: enabler of the PC and of each pipe register (1 = load).
REQ-010 Ports sync_reset_D and sync_reset_E SHALL be outputs, 1 bit each: active-low synchronous clear of the Decode and Execute pipe registers.
REQ-011 Port state_o SHALL be output, 2 bits: current FSM state.
REQ-012 Port timeout_err SHALL be output, 1 bit: sticky memory-timeout flag.
REQ-013 Ports stall_cycles and flush_count SHALL be outputs, CNT_W bits each: performance counters.

Function
REQ-014 load_use SHALL be mem_read_E & reg_write_E & (rd_E != 0) & (rd_E == rs1_D | rd_E == rs2_D).
REQ-015 mem_stall SHALL be mem_req_M & ~mem_ready_M.
REQ-016 The FSM SHALL have states RUN=0, LOAD_STALL=1, MEM_WAIT=2, all outputs combinational from state and current inputs.
REQ-017 Priority SHALL be mem_stall > branch_taken_E > load_use > none.
REQ-018 On mem_stall in any state, all five enables SHALL be 0, both sync_resets 1, and next state MEM_WAIT.
REQ-019 On branch_taken_E without mem_stall, all enables SHALL be 1, sync_reset_D=0, sync_reset_E=0, and next state RUN; flush_count increments.
REQ-020 On load_use in RUN without branch or mem_stall, enable_F=0, enable_D=0, enable_E/M/W=1, sync_reset_E=0, sync_reset_D=1, and next state LOAD_STALL.
REQ-021 In LOAD_STALL, load_use SHALL be ignored and the state SHALL otherwise behave as RUN, returning to RUN; exactly one bubble per load-use.
REQ-022 With no event, all enables SHALL be 1, sync_resets 1, and next state RUN.
REQ-023 In MEM_WAIT, wait_cnt SHALL increment per cycle while mem_stall and saturate at MEM_TIMEOUT; reaching MEM_TIMEOUT sets timeout_err, which clears only on reset.
REQ-024 wait_cnt SHALL start at 1 on MEM_WAIT entry and be cleared on exit.
REQ-025 In the cycle mem_ready_M=1 while in MEM_WAIT, the REQ-019/020/022 rules SHALL apply, with branch and load_use evaluated on that cycle's inputs.
REQ-026 stall_cycles SHALL increment every cycle enable_F=0 out of reset; both counters SHALL saturate at all-ones, never wrapping.

Reset
REQ-027 While async_reset=0, state SHALL be RUN, wait_cnt, stall_cycles, flush_count and timeout_err 0, all enables 0, and sync_reset_D/E 0.
REQ-028 Assertion mid-MEM_WAIT or mid-LOAD_STALL SHALL abort immediately; on the first edge after release, behaviour SHALL follow RUN.

Structure
REQ-029 Package hazard_pkg SHALL hold the state enum, the RUN/LOAD_STALL/MEM_WAIT encodings and the default MEM_TIMEOUT and CNT_W values.
REQ-030 One sub-module, sat_counter (parameterised width, inc, async clear), SHALL implement stall_cycles and flush_count.

Verification
REQ-031 rd_E=5, mem_read_E=1, reg_write_E=1, rs1_D=5 -> one cycle enable_F=enable_D=0, sync_reset_E=0, next cycle enables all 1, stall_cycles=1.
REQ-032 Same with rd_E=0 -> no stall, all enables 1.
REQ-033 mem_req_M=1, mem_ready_M=0 for 4 cycles then 1 -> enables 0 for 4 cycles, state_o=2, stall_cycles=4, then RUN.
REQ-034 branch_taken_E=1 together with load_use -> sync_reset_D=sync_reset_E=0, enables 1, flush_count=1, no stall.
REQ-035 MEM_TIMEOUT=8, mem_ready_M held 0 for 10 cycles -> timeout_err=1 from 8th wait cycle, stays 1 after ready, clears only on async_reset=0.
REQ-036 async_reset=0 during MEM_WAIT -> enables 0, sync_resets 0, counters 0 immediately; after release state_o=0.
